// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: types, constants and decode helpers shared by the
// memory arbiter and its lane aligner.
//   arb_state_e       arbiter FSM states
//   F3_*              RISC-V load/store funct3 encodings
//   STRB_*            unshifted byte-lane strobes
//   access_bad()      misaligned or undefined access decode
//   store_strb()      unshifted strobe for a store funct3
package mem_arbiter_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIfRd,
      StDRd,
      StRmwRd,
      StDWr
   } arb_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [3:0] STRB_B = 4'b0001;
   localparam logic [3:0] STRB_H = 4'b0011;
   localparam logic [3:0] STRB_W = 4'b1111;

   // Undefined encodings are reported like misalignment. Stores have no
   // unsigned forms, so 100/101 with we=1 are undefined too.
   function automatic logic access_bad(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] off);
      logic bad;
      bad = 1'b1;
      if (we) begin
         case (funct3)
            F3_SB:   bad = 1'b0;
            F3_SH:   bad = off[0];
            F3_SW:   bad = (off != 2'b00);
            default: bad = 1'b1;
         endcase
      end else begin
         case (funct3)
            F3_LB, F3_LBU: bad = 1'b0;
            F3_LH, F3_LHU: bad = off[0];
            F3_LW:         bad = (off != 2'b00);
            default:       bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

   function automatic logic [3:0] store_strb(input logic [2:0] funct3);
      logic [3:0] s;
      case (funct3)
         F3_SB:   s = STRB_B;
         F3_SH:   s = STRB_H;
         default: s = STRB_W;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane shifting shared by loads and stores.
//   off_i    byte offset within the word (addr[1:0])
//   strb_i   unshifted lane strobe for the store size
//   wdata_i  LSB-justified store data
//   rdata_i  word read from memory
//   load_o   rdata_i shifted right so the addressed byte sits in [7:0]
//   store_o  wdata_i shifted left into the addressed lanes
//   strb_o   strb_i shifted left into the addressed lanes
//   merge_o  rdata_i with the strobed lanes replaced by store_o
module mem_lane_align (
   input  logic [1:0]  off_i,
   input  logic [3:0]  strb_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] load_o,
   output logic [31:0] store_o,
   output logic [3:0]  strb_o,
   output logic [31:0] merge_o
);

   logic [4:0] shamt;

   assign shamt   = {off_i, 3'b000};
   assign load_o  = rdata_i >> shamt;
   assign store_o = wdata_i << shamt;
   assign strb_o  = strb_i << off_i;

   always_comb begin
      merge_o = rdata_i;
      for (int b = 0; b < 4; b++) begin
         if (strb_o[b]) begin
            merge_o[8*b +: 8] = store_o[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one single-port memory between instruction fetch
// and the MEM stage. Data wins in IDLE unless fetch has been passed over
// STARVE_LIMIT consecutive times. One access is outstanding at a time.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr            fetch request and word address
//   if_ready/if_rdata         fetch completion pulse and data
//   d_req/d_we/d_funct3       data request, direction, access size
//   d_addr/d_wdata            data byte address and store data
//   d_ready/d_rdata/d_err     data completion pulse, load data, misalignment
//   mem_en/mem_we/mem_addr    memory command
//   mem_wstrb/mem_wdata       memory write lanes and data
//   mem_rdata                 memory read data, one cycle after a read
//   stall                     some request is pending and not acknowledged
//
// Build option: define MEM_ARB_RMW_EN to perform sub-word stores as a full
// read-modify-write (read, merged full-word write, ready) instead of a
// single byte-strobed write.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [2:0]  d_funct3,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        stall
);

   localparam int unsigned CntW = $clog2(STARVE_LIMIT + 2);

   arb_state_e      state_q, state_d;
   logic [CntW-1:0] starve_q, starve_d;
   logic            err_q, err_d;

   logic        d_bad;
   logic        fetch_wins;
   logic        grant_if, grant_d;
   logic [31:0] load_data, store_data, merge_data;
   logic [3:0]  lane_strb;
   logic        unused_bits;

   assign d_bad      = access_bad(d_we, d_funct3, d_addr[1:0]);
   assign fetch_wins = if_req && (!d_req || (starve_q == CntW'(STARVE_LIMIT)));

`ifdef MEM_ARB_RMW_EN
   logic d_sub;
   assign d_sub       = (d_funct3 != F3_SW);
   assign unused_bits = ^{if_addr[1:0], lane_strb};
`else
   assign unused_bits = ^if_addr[1:0];
`endif

   mem_lane_align u_align (
      .off_i   (d_addr[1:0]),
      .strb_i  (store_strb(d_funct3)),
      .wdata_i (d_wdata),
      .rdata_i (mem_rdata),
      .load_o  (load_data),
      .store_o (store_data),
      .strb_o  (lane_strb),
      .merge_o (merge_data)
   );

   always_comb begin
      state_d   = state_q;
      starve_d  = starve_q;
      err_d     = err_q;
      grant_if  = 1'b0;
      grant_d   = 1'b0;
      if_ready  = 1'b0;
      if_rdata  = '0;
      d_ready   = 1'b0;
      d_rdata   = '0;
      d_err     = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wstrb = '0;
      mem_wdata = '0;

      unique case (state_q)
         StIdle: begin
            if (fetch_wins) begin
               grant_if = 1'b1;
               mem_en   = 1'b1;
               mem_addr = {if_addr[31:2], 2'b00};
               state_d  = StIfRd;
            end else if (d_req) begin
               grant_d = 1'b1;
               err_d   = d_bad;
               if (d_bad) begin
                  // Answered with an error, the memory is never touched.
                  state_d = StDWr;
               end else if (!d_we) begin
                  mem_en   = 1'b1;
                  mem_addr = {d_addr[31:2], 2'b00};
                  state_d  = StDRd;
`ifdef MEM_ARB_RMW_EN
               end else if (d_sub) begin
                  mem_en   = 1'b1;
                  mem_addr = {d_addr[31:2], 2'b00};
                  state_d  = StRmwRd;
               end else begin
                  mem_en    = 1'b1;
                  mem_we    = 1'b1;
                  mem_addr  = {d_addr[31:2], 2'b00};
                  mem_wstrb = STRB_W;
                  mem_wdata = store_data;
                  state_d   = StDWr;
               end
`else
               end else begin
                  mem_en    = 1'b1;
                  mem_we    = 1'b1;
                  mem_addr  = {d_addr[31:2], 2'b00};
                  mem_wstrb = lane_strb;
                  mem_wdata = store_data;
                  state_d   = StDWr;
               end
`endif
            end
         end
         StIfRd: begin
            if_ready = 1'b1;
            if_rdata = mem_rdata;
            state_d  = StIdle;
         end
         StDRd: begin
            d_ready = 1'b1;
            d_rdata = load_data;
            state_d = StIdle;
         end
         StRmwRd: begin
            // Old word is on mem_rdata; write it back with the new lanes.
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {d_addr[31:2], 2'b00};
            mem_wstrb = STRB_W;
            mem_wdata = merge_data;
            state_d   = StDWr;
         end
         StDWr: begin
            d_ready = 1'b1;
            d_err   = err_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (!if_req || grant_if) begin
         starve_d = '0;
      end else if (grant_d) begin
         starve_d = starve_q + 1'b1;
      end

      stall = (if_req && !if_ready) || (d_req && !d_ready);

      // Reset aborts whatever is in flight: no pulses, no memory command.
      if (rst) begin
         if_ready  = 1'b0;
         if_rdata  = '0;
         d_ready   = 1'b0;
         d_rdata   = '0;
         d_err     = 1'b0;
         mem_en    = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wstrb = '0;
         mem_wdata = '0;
         stall     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         starve_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

`ifdef MEM_ARB_RMW_EN
   localparam bit RmwOn = 1'b1;
`else
   localparam bit RmwOn = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [2:0]  d_funct3;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        stall;

   mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ready  (if_ready),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_funct3  (d_funct3),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ready   (d_ready),
      .d_rdata   (d_rdata),
      .d_err     (d_err),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wstrb (mem_wstrb),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall     (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory slave: 256 words, indexed by address bits [9:2].
   logic [31:0] mem_model [0:255];
   int          mem_en_cnt = 0;
   logic [3:0]  last_wstrb = '0;
   logic [31:0] last_wdata = '0;
   logic [31:0] last_waddr = '0;

   always @(posedge clk) begin
      if (mem_en) mem_en_cnt <= mem_en_cnt + 1;
      if (mem_en && mem_we) begin
         last_wstrb <= mem_wstrb;
         last_wdata <= mem_wdata;
         last_waddr <= mem_addr;
         for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) mem_model[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
         end
      end
      if (mem_en && !mem_we) mem_rdata <= mem_model[mem_addr[9:2]];
   end

   // Reference: plain byte-addressed memory image.
   logic [7:0] ref_b [0:1023];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic set_word(input logic [31:0] a, input logic [31:0] v);
      int base;
      base = int'(a[9:2]) * 4;
      mem_model[a[9:2]] = v;
      for (int i = 0; i < 4; i++) ref_b[base + i] = 8'(v >> (8 * i));
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      int base;
      base = int'(a[9:2]) * 4;
      return {ref_b[base + 3], ref_b[base + 2], ref_b[base + 1], ref_b[base]};
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a);
      logic [31:0] r;
      int base, off;
      base = int'(a[9:2]) * 4;
      off  = int'(a[1:0]);
      r    = '0;
      for (int i = 0; i < 4 - off; i++) r = r | (32'(ref_b[base + off + i]) << (8 * i));
      return r;
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input int sz);
      for (int i = 0; i < sz; i++) ref_b[int'(a[9:0]) + i] = 8'(wd >> (8 * i));
   endtask

   // Bytes per access, 0 for an undefined encoding.
   function automatic int acc_size(input logic we, input logic [2:0] f3);
      int s;
      s = 0;
      if (we) begin
         if (f3 == 3'd0) s = 1;
         else if (f3 == 3'd1) s = 2;
         else if (f3 == 3'd2) s = 4;
      end else begin
         if (f3 == 3'd0 || f3 == 3'd4) s = 1;
         else if (f3 == 3'd1 || f3 == 3'd5) s = 2;
         else if (f3 == 3'd2) s = 4;
      end
      return s;
   endfunction

   // Starts at posedge+1 with the arbiter idle; returns at posedge+1 after the
   // ready cycle. lat is the cycle of d_ready counting the grant cycle as 1.
   task automatic run_data(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic er, output int lat, output int men);
      int en0;
      en0      = mem_en_cnt;
      d_req    = 1'b1;
      d_we     = we;
      d_funct3 = f3;
      d_addr   = a;
      d_wdata  = wd;
      lat      = 0;
      rd       = '0;
      er       = 1'b0;
      for (int n = 1; n <= 8 && lat == 0; n++) begin
         @(negedge clk);
         if (d_ready) begin
            lat = n;
            rd  = d_rdata;
            er  = d_err;
         end
         @(posedge clk);
         #1;
      end
      d_req = 1'b0;
      men   = mem_en_cnt - en0;
   endtask

   task automatic run_fetch(input logic [31:0] a, output logic [31:0] rd, output int lat,
                            output logic [31:0] first_addr, output logic first_en);
      if_req     = 1'b1;
      if_addr    = a;
      lat        = 0;
      rd         = '0;
      first_addr = '0;
      first_en   = 1'b0;
      for (int n = 1; n <= 8 && lat == 0; n++) begin
         @(negedge clk);
         if (n == 1) begin
            first_addr = mem_addr;
            first_en   = mem_en && !mem_we;
         end
         if (if_ready) begin
            lat = n;
            rd  = if_rdata;
         end
         @(posedge clk);
         #1;
      end
      if_req = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] init;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic [31:0] exp_word;
      int          exp_lat;
      int          exp_men;
   } vec_t;

   localparam int NV = 13;
   vec_t vt [NV];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, fa, a, wd, exp_rd, r, w3addr;
      logic        er, fe, we, bad, w3en, stall2, stall3;
      logic [2:0]  f3;
      int          lat, men, dcyc, icyc, dcount, dbefore, sz, off, exp_lat, exp_men;

      //                 we    f3      addr          wdata         init          exp_rd        err   exp_word      lat              men
      vt[0]  = '{1'b0, 3'b001, 32'h0000_0202, 32'h0,         32'hBEEF_1234, 32'h0000_BEEF, 1'b0, 32'hBEEF_1234, 2,               1};
      vt[1]  = '{1'b0, 3'b010, 32'h0000_0204, 32'h0,         32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 2,               1};
      vt[2]  = '{1'b0, 3'b100, 32'h0000_0209, 32'h0,         32'h1122_3344, 32'h0011_2233, 1'b0, 32'h1122_3344, 2,               1};
      vt[3]  = '{1'b0, 3'b000, 32'h0000_020F, 32'h0,         32'h1122_3344, 32'h0000_0011, 1'b0, 32'h1122_3344, 2,               1};
      vt[4]  = '{1'b1, 3'b000, 32'h0000_0203, 32'h0000_00AB, 32'h1122_3344, 32'h0,         1'b0, 32'hAB22_3344, RmwOn ? 3 : 2,   RmwOn ? 2 : 1};
      vt[5]  = '{1'b1, 3'b001, 32'h0000_0216, 32'h0000_5566, 32'h1122_3344, 32'h0,         1'b0, 32'h5566_3344, RmwOn ? 3 : 2,   RmwOn ? 2 : 1};
      vt[6]  = '{1'b1, 3'b010, 32'h0000_0218, 32'hDEAD_BEEF, 32'h0,         32'h0,         1'b0, 32'hDEAD_BEEF, 2,               1};
      vt[7]  = '{1'b1, 3'b010, 32'h0000_0201, 32'h5A5A_5A5A, 32'h1122_3344, 32'h0,         1'b1, 32'h1122_3344, 2,               0};
      vt[8]  = '{1'b0, 3'b001, 32'h0000_0223, 32'h0,         32'h1122_3344, 32'h0,         1'b1, 32'h1122_3344, 2,               0};
      vt[9]  = '{1'b0, 3'b011, 32'h0000_0224, 32'h0,         32'h1122_3344, 32'h0,         1'b1, 32'h1122_3344, 2,               0};
      vt[10] = '{1'b1, 3'b111, 32'h0000_0228, 32'hFFFF_FFFF, 32'h1122_3344, 32'h0,         1'b1, 32'h1122_3344, 2,               0};
      vt[11] = '{1'b1, 3'b000, 32'h0000_022C, 32'hFFFF_FF7E, 32'h1122_3344, 32'h0,         1'b0, 32'h1122_337E, RmwOn ? 3 : 2,   RmwOn ? 2 : 1};
      vt[12] = '{1'b1, 3'b001, 32'h0000_0231, 32'h0000_7777, 32'h1122_3344, 32'h0,         1'b1, 32'h1122_3344, 2,               0};

      for (int i = 0; i < 1024; i++) ref_b[i] = 8'h00;
      for (int i = 0; i < 256; i++) mem_model[i] = '0;

      // Reset with both requests asserted: every output must be low.
      rst = 1'b1; if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_we = 1'b1;
      d_funct3 = 3'b010; d_addr = 32'h200; d_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("rst_ctrl", 0, {26'd0, mem_en, mem_we, stall, d_ready, if_ready, d_err}, 32'h0);
      chk("rst_addr", 0, mem_addr, 32'h0);
      chk("rst_wstrb", 0, {28'd0, mem_wstrb}, 32'h0);
      @(posedge clk); #1;
      if_req = 1'b0; d_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Fetch only.
      set_word(32'h100, 32'h0000_0013);
      if_req = 1'b1; if_addr = 32'h100;
      icyc = 0; stall2 = 1'b1;
      for (int n = 1; n <= 8 && icyc == 0; n++) begin
         @(negedge clk);
         if (n == 1) begin
            chk("fetch_cmd", 0, {30'd0, mem_en, mem_we}, 32'h2);
            chk("fetch_addr", 0, mem_addr, 32'h100);
            chk("fetch_stall", 1, {31'd0, stall}, 32'h1);
         end
         if (if_ready) begin
            icyc = n;
            rd = if_rdata;
            stall2 = stall;
         end
         @(posedge clk); #1;
      end
      if_req = 1'b0;
      chk("fetch_lat", 0, icyc, 2);
      chk("fetch_data", 0, rd, 32'h0000_0013);
      chk("fetch_stall", 2, {31'd0, stall2}, 32'h0);

      // Table vectors.
      for (int i = 0; i < NV; i++) begin
         set_word(vt[i].addr, vt[i].init);
         run_data(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rd, er, lat, men);
         chk("vec_lat", i, lat, vt[i].exp_lat);
         chk("vec_err", i, {31'd0, er}, {31'd0, vt[i].exp_err});
         chk("vec_men", i, men, vt[i].exp_men);
         if (!vt[i].we && !vt[i].exp_err) chk("vec_rdata", i, rd, vt[i].exp_rd);
         chk("vec_word", i, mem_model[vt[i].addr[9:2]], vt[i].exp_word);
      end

      // SB into the top lane: check the memory command itself.
      set_word(32'h200, 32'h1122_3344);
      run_data(1'b1, 3'b000, 32'h203, 32'h0000_00AB, rd, er, lat, men);
      chk("sb_waddr", 0, last_waddr, 32'h200);
`ifdef MEM_ARB_RMW_EN
      chk("sb_wstrb", 0, {28'd0, last_wstrb}, 32'hF);
      chk("sb_wdata", 0, last_wdata, 32'hAB22_3344);
      chk("sb_men", 0, men, 2);
`else
      chk("sb_wstrb", 0, {28'd0, last_wstrb}, 32'h8);
      chk("sb_wdata", 0, {24'd0, last_wdata[31:24]}, 32'hAB);
      chk("sb_men", 0, men, 1);
`endif

      // Simultaneous load and fetch: data first, fetch granted after d_ready.
      set_word(32'h204, 32'h0BAD_F00D);
      set_word(32'h300, 32'h0000_0093);
      d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h204;
      if_req = 1'b1; if_addr = 32'h300;
      dcyc = 0; icyc = 0; fa = '0; w3addr = '0; w3en = 1'b0; stall2 = 1'b0; stall3 = 1'b0;
      for (int n = 1; n <= 10 && icyc == 0; n++) begin
         @(negedge clk);
         if (n == 1) fa = mem_addr;
         if (n == 2) stall2 = stall;
         if (n == 3) begin
            w3addr = mem_addr;
            w3en = mem_en;
            stall3 = stall;
         end
         if (d_ready && dcyc == 0) begin
            dcyc = n;
            r = d_rdata;
         end
         if (if_ready) begin
            icyc = n;
            rd = if_rdata;
         end
         @(posedge clk); #1;
         if (dcyc != 0) d_req = 1'b0;
      end
      if_req = 1'b0; d_req = 1'b0;
      chk("sim_first_addr", 0, fa, 32'h204);
      chk("sim_d_lat", 0, dcyc, 2);
      chk("sim_d_data", 0, r, 32'h0BAD_F00D);
      chk("sim_stall", 2, {31'd0, stall2}, 32'h1);
      chk("sim_fetch_grant", 3, {31'd0, w3en}, 32'h1);
      chk("sim_fetch_addr", 3, w3addr, 32'h300);
      chk("sim_stall", 3, {31'd0, stall3}, 32'h1);
      chk("sim_if_lat", 0, icyc, 4);
      chk("sim_if_data", 0, rd, 32'h0000_0093);

      // Starvation: back-to-back loads with fetch pending the whole time.
      d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h204;
      if_req = 1'b1; if_addr = 32'h300;
      dcount = 0; dbefore = -1; icyc = 0;
      for (int n = 1; n <= 20 && icyc == 0; n++) begin
         @(negedge clk);
         if (d_ready) dcount++;
         if (if_ready) begin
            icyc = n;
            dbefore = dcount;
         end
         @(posedge clk); #1;
      end
      if_req = 1'b0; d_req = 1'b0;
      chk("starve_grants", 0, dbefore, 4);
      chk("starve_if_lat", 0, icyc, 10);

      // Reset in the middle of a load: no ready pulse, no memory command.
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h204;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ready", 0, {30'd0, d_ready, mem_en}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; d_req = 1'b0;
      @(negedge clk);
      chk("abort_ready", 1, {30'd0, d_ready, mem_en}, 32'h0);
      @(posedge clk); #1;

      // Random traffic against the byte-image reference.
      for (int i = 0; i < 256; i++) begin
         r = $urandom();
         set_word(32'(i * 4), r);
      end
      for (int it = 0; it < 300; it++) begin
         r = $urandom();
         if ($urandom_range(0, 3) == 0) begin
            a = {r[31:2], 2'b00};
            run_fetch(a, rd, lat, fa, fe);
            chk("rnd_if_lat", it, lat, 2);
            chk("rnd_if_cmd", it, {31'd0, fe}, 32'h1);
            chk("rnd_if_addr", it, fa, a);
            chk("rnd_if_data", it, rd, ref_word(a));
         end else begin
            a   = r;
            we  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            wd  = $urandom();
            sz  = acc_size(we, f3);
            off = int'(a[1:0]);
            bad = (sz == 0);
            if (!bad) bad = (off % sz) != 0;
            exp_lat = (!bad && we && sz < 4 && RmwOn) ? 3 : 2;
            exp_men = bad ? 0 : ((we && sz < 4 && RmwOn) ? 2 : 1);
            exp_rd  = ref_load(a);
            if (!bad && we) ref_store(a, wd, sz);
            run_data(we, f3, a, wd, rd, er, lat, men);
            chk("rnd_lat", it, lat, exp_lat);
            chk("rnd_err", it, {31'd0, er}, {31'd0, bad});
            chk("rnd_men", it, men, exp_men);
            if (!bad && !we) chk("rnd_rdata", it, rd, exp_rd);
            chk("rnd_word", it, mem_model[a[9:2]], ref_word(a));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
